// File: rtl/proc2_pkg.sv
// proc2 shared types: opcodes, FSM steps, instruction fields.
package proc2_pkg;

  localparam int unsigned IR_W     = 9;
  localparam int unsigned OP_W     = 3;
  localparam int unsigned RSEL_W   = 3;
  localparam int unsigned NUM_REGS = 8;

  typedef enum logic [OP_W-1:0] {
    OP_MV   = 3'b000,
    OP_MVI  = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_AND  = 3'b100,
    OP_MVNZ = 3'b101
  } opcode_t;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

  // Instruction word: III XXX YYY
  typedef struct packed {
    opcode_t             op;
    logic [RSEL_W-1:0]   rx;
    logic [RSEL_W-1:0]   ry;
  } ir_t;

endpackage

// File: rtl/proc2_if.sv
// proc2 external bus: instruction/data in, bus/status out.
interface proc2_if #(
  parameter int unsigned DATA_W = 16
);
  logic [DATA_W-1:0] DIN;
  logic              Run;
  logic              Done;
  logic [DATA_W-1:0] BusWires;
  logic              Zero;

  modport master (output DIN, output Run, input Done, input BusWires, input Zero);
  modport slave  (input DIN, input Run, output Done, output BusWires, output Zero);
endinterface

// File: rtl/proc2_alu.sv
// proc2 ALU: add/sub/and of the A register and the bus, feeding G.
module proc2_alu
  import proc2_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  opcode_t           op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] result_c
);
  // Opcode-selected operation, wraps modulo 2^DATA_W
  always_comb begin
    result_c = a_i + b_i;
    case (op_i)
      OP_SUB:  result_c = a_i - b_i;
      OP_AND:  result_c = a_i & b_i;
      default: ;
    endcase
  end
endmodule

// File: rtl/regn.sv
// Parametrised enabled register with synchronous active-high clear.
module regn #(
  parameter int unsigned N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);
  logic [N-1:0] q_q, q_d;

  // Load on enable, otherwise hold
  always_comb q_d = en ? d : q_q;

  // Storage flop
  always_ff @(posedge clk) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q = q_q;
endmodule

// File: rtl/proc2.sv
// proc2: multi-cycle bus processor, 9-bit instructions over a shared bus.
// Build option: PROC2_MVNZ_EN enables opcode 101 as mvnz (else illegal/no-op).
module proc2
  import proc2_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic   Clock,
  input  logic   Reset,
  proc2_if.slave bus
);
  state_t              state_q, state_d;
  ir_t                 ir_q, ir_d;
  logic                zero_q, zero_d;
  logic [NUM_REGS-1:0] r_in, r_out;
  logic                a_in, g_in, g_out, din_out, done_c;
  logic [DATA_W-1:0]   r_q [NUM_REGS];
  logic [DATA_W-1:0]   a_q, g_q, alu_c, bus_c;

  // Step sequencing and bus/register control decode
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    r_in    = '0;
    r_out   = '0;
    a_in    = 1'b0;
    g_in    = 1'b0;
    g_out   = 1'b0;
    din_out = 1'b0;
    done_c  = 1'b0;
    case (state_q)
      T0: begin
        if (bus.Run) begin
          ir_d    = ir_t'(bus.DIN[DATA_W-1 -: IR_W]);
          state_d = T1;
        end
      end
      T1: begin
        state_d = T0;
        case (ir_q.op)
          OP_MV: begin
            r_out[ir_q.ry] = 1'b1;
            r_in[ir_q.rx]  = 1'b1;
            done_c         = 1'b1;
          end
          OP_MVI: begin
            din_out       = 1'b1;
            r_in[ir_q.rx] = 1'b1;
            done_c        = 1'b1;
          end
          OP_ADD, OP_SUB, OP_AND: begin
            r_out[ir_q.rx] = 1'b1;
            a_in           = 1'b1;
            state_d        = T2;
          end
`ifdef PROC2_MVNZ_EN
          OP_MVNZ: begin
            if (!zero_q) begin
              r_out[ir_q.ry] = 1'b1;
              r_in[ir_q.rx]  = 1'b1;
            end
            done_c = 1'b1;
          end
`endif
          default: done_c = 1'b1;
        endcase
      end
      T2: begin
        r_out[ir_q.ry] = 1'b1;
        g_in           = 1'b1;
        state_d        = T3;
      end
      T3: begin
        g_out         = 1'b1;
        r_in[ir_q.rx] = 1'b1;
        done_c        = 1'b1;
        state_d       = T0;
      end
      default: state_d = T0;
    endcase
  end

  // One-hot AND-OR bus mux; zero when nothing drives
  always_comb begin
    bus_c = '0;
    if (din_out) bus_c = bus_c | bus.DIN;
    if (g_out)   bus_c = bus_c | g_q;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      if (r_out[RSEL_W'(i)]) bus_c = bus_c | r_q[RSEL_W'(i)];
    end
  end

  // Zero tracks the value G is about to take
  always_comb zero_d = g_in ? (alu_c == '0) : zero_q;

  // FSM, IR and zero-flag state
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= T0;
      ir_q    <= '0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      zero_q  <= zero_d;
    end
  end

  for (genvar i = 0; i < int'(NUM_REGS); i++) begin : g_reg
    regn #(.N(DATA_W)) u_r (
      .clk(Clock), .rst(Reset), .en(r_in[i]), .d(bus_c), .q(r_q[i])
    );
  end

  regn #(.N(DATA_W)) u_a (
    .clk(Clock), .rst(Reset), .en(a_in), .d(bus_c), .q(a_q)
  );

  regn #(.N(DATA_W)) u_g (
    .clk(Clock), .rst(Reset), .en(g_in), .d(alu_c), .q(g_q)
  );

  proc2_alu #(.DATA_W(DATA_W)) u_alu (
    .op_i(ir_q.op), .a_i(a_q), .b_i(bus_c), .result_c(alu_c)
  );

  assign bus.Done     = done_c;
  assign bus.BusWires = bus_c;
  assign bus.Zero     = zero_q;
endmodule
